data_mem_responder: RTL

//  Data-memory responder: the target side of the core's data port (DataAddr/DataOut/WriteData/ReadData).

---
 rtl/data_mem_responder_if.sv | 14 +
 rtl/data_mem_responder.sv | 88 ++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Core data-port bundle between the core (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
    parameter int WORD_SIZE = 16
);
    logic [WORD_SIZE-1:0] DataAddr;
    logic [WORD_SIZE-1:0] DataOut;
    logic                 WriteData;
    logic                 ReadData;
    logic [WORD_SIZE-1:0] DataIn;
    logic                 DataDone;

    modport master (output DataAddr, DataOut, WriteData, ReadData, input DataIn, DataDone);
    modport slave  (input DataAddr, DataOut, WriteData, ReadData, output DataIn, DataDone);
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM behind a 2-stage response pipeline (read data 2 cycles after request).
// Optional MMIO (LEDR at 16'hFFF0, SW at 16'hFFF1) enabled by defining DATA_MMIO_EN.
module data_mem_responder #(
    parameter int    WORD_SIZE = 16,
    parameter int    DEPTH     = 256,
    parameter string INIT_FILE = ""
) (
    input  logic                 Clock,
    input  logic                 Resetn,
`ifdef DATA_MMIO_EN
    output logic [WORD_SIZE-1:0] LEDR,
    input  logic [WORD_SIZE-1:0] SW,
`endif
    data_mem_responder_if.slave  bus
);
    localparam int ADDR_BITS = $clog2(DEPTH);

    typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_LED, SEL_SW} sel_t;

    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [1:0]           vld_pipe;
    logic                 s1_rd;
    sel_t                 s1_sel;
    logic [ADDR_BITS-1:0] s1_addr;
    logic [WORD_SIZE-1:0] data_in;
    logic [WORD_SIZE-1:0] rd_word;
    logic                 req;
    sel_t                 sel;

    assign req = bus.ReadData | bus.WriteData;

    // Only the low ADDR_BITS index the RAM, and only once the upper bits are known to be zero.
    always_comb begin
        sel = SEL_NONE;
        if (bus.DataAddr[WORD_SIZE-1:ADDR_BITS] == '0) sel = SEL_RAM;
`ifdef DATA_MMIO_EN
        else if (bus.DataAddr == WORD_SIZE'(16'hFFF0)) sel = SEL_LED;
        else if (bus.DataAddr == WORD_SIZE'(16'hFFF1)) sel = SEL_SW;
`endif
    end

    // RAM survives reset; a write commits at the stage-1 edge so a read issued in the same cycle
    // or the next one sees the new value.
    always_ff @(posedge Clock) begin
        if (Resetn && bus.WriteData && sel == SEL_RAM)
            mem[bus.DataAddr[ADDR_BITS-1:0]] <= bus.DataOut;
    end

`ifdef DATA_MMIO_EN
    always_ff @(posedge Clock) begin
        if (!Resetn)                                  LEDR <= '0;
        else if (bus.WriteData && sel == SEL_LED)     LEDR <= bus.DataOut;
    end
`endif

    always_comb begin
        rd_word = '0;
        if (vld_pipe[0] && s1_rd) begin
            case (s1_sel)
                SEL_RAM: rd_word = mem[s1_addr];
`ifdef DATA_MMIO_EN
                SEL_LED: rd_word = LEDR;
                SEL_SW:  rd_word = SW;
`endif
                default: rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            vld_pipe <= '0;
            s1_rd    <= 1'b0;
            s1_sel   <= SEL_NONE;
            s1_addr  <= '0;
            data_in  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], req};
            s1_rd    <= bus.ReadData;
            s1_sel   <= sel;
            s1_addr  <= bus.DataAddr[ADDR_BITS-1:0];
            data_in  <= rd_word;
        end
    end

    assign bus.DataIn   = data_in;
    assign bus.DataDone = vld_pipe[1];
endmodule
